divisible_by_5: RTL and testbench
=================================

// Module: divisible_by_5
// PURPOSE
//   Serial divisibility checker: consumes one bit per clock, MSB first, forming a growing
//   binary number N. Asserts out when N mod 5 == 0.
//   Used as a streaming front-end check on serial data links. No framing: the stream runs from reset.
// PARAMETERS
//   none; the divisor is fixed at 5. The remainder encoding lives in the package.
// PORTS
//   clk    input   1  rising-edge clock; the only clock
//   reset  input   1  asynchronous, active-low reset
//   in     input   1  next stream bit, MSB first, sampled on every rising clk edge
//   out    output  1  registered; 1 when all bits sampled since reset form a value divisible by 5
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - Moore FSM with 5 states S0..S4. State Sk means the running value mod 5 == k.
//   - Update on every rising edge with reset high: next = (2*k + in) mod 5.
//       S0: in=0->S0, in=1->S1    S1: in=0->S2, in=1->S3    S2: in=0->S4, in=1->S0
//       S3: in=0->S1, in=1->S2    S4: in=0->S3, in=1->S4
//   - out = (state == S0), decoded from a registered state. No combinational path from in to out.
//   - Latency: a bit sampled at edge t is reflected in out immediately after edge t.
//   - Reset asserted (reset=0), at any time including mid-stream:
//     - state -> S0 and out -> 1 immediately, without waiting for clk.
//     - An empty stream has value 0, which is divisible by 5.
//   - While reset is low, in is ignored.
//   - Reset deassertion is synchronized by the integrator. The first edge with reset=1 samples the MSB.
//   - Stream length is unbounded; only the remainder is stored, so nothing wraps or overflows.
//   - Leading zeros keep the state at S0. out stays 1 until the first 1 bit arrives.
//   - Illegal state codes (5..7) recover to S0 on the next edge. Encoding: 3-bit binary, S0=3'd0.
//   - Any X/Z on in while reset=1 drives the state to S0. A simulation-only warning is
//     printed under `ifndef SYNTHESIS.
// CONFIGURATION
//   - Macro DIV5_REM_OUT_EN defined: adds output port rem [2:0].
//     - rem holds the current remainder k (0..4), registered and reset to 0.
//     - out still equals (rem == 0).
//   - Macro not defined: rem is absent. The port list is exactly clk, reset, in, out.
// STRUCTURE
//   - Package div5_pkg:
//     - state encodings S0..S4 (localparams or typedef enum [2:0]);
//     - constant DIVISOR = 5;
//     - function next_rem(rem, bit) implementing the transition table above.
//   - Optional sub-module mod5_step: purely combinational next-state logic (rem, in -> next_rem).
//     The top holds only the state register and the output decode.
// TESTING
//   1. Reset: hold reset=0 with no clk edges -> out=1 asynchronously. Release, then keep in=0
//      for 4 edges -> out stays 1.
//   2. Stream 0,1,0,1,0,1,0,1,1 (values 0,1,2,5,10,21,42,85,171) -> out after each edge:
//      1,0,0,1,1,0,0,1,0.
//   3. Stream 1,1,1,1 (value 15) -> out 0,0,0,1.
//      Continue with 0 (value 30) -> out 1.
//   4. Mid-stream reset: after 1,1 (rem 3), pulse reset low between edges -> out=1 at once.
//      Then feed 1,0,1 (value 5) -> out 0,0,1.
//   5. Exhaustive check: for every 8-bit value, shift in MSB first after reset. out must equal
//      (value % 5 == 0) after every prefix, checked against a reference model.
//   6. With DIV5_REM_OUT_EN defined: stream 1,0,0,1 -> rem 1,2,4,4, out 0,0,0,0.
//      Then feed 0 -> rem 3.

Source files
------------

// File: rtl/div5_pkg.sv
// Shared definitions for the serial divide-by-5 checker: remainder encoding and the
// one-bit remainder update used by the next-state logic.
package div5_pkg;

  localparam int DIVISOR = 5;
  localparam int REM_W   = 3;

  typedef enum logic [REM_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } rem_e;

  // (2*rem + b) mod 5. Illegal codes 5..7 and unknown bits fall into the default,
  // which lands on S0.
  function automatic logic [REM_W-1:0] next_rem(input logic [REM_W-1:0] rem,
                                                input logic             b);
    logic [REM_W-1:0] nxt;
    nxt = S0;
    case ({rem, b})
      4'b000_0: nxt = S0;
      4'b000_1: nxt = S1;
      4'b001_0: nxt = S2;
      4'b001_1: nxt = S3;
      4'b010_0: nxt = S4;
      4'b010_1: nxt = S0;
      4'b011_0: nxt = S1;
      4'b011_1: nxt = S2;
      4'b100_0: nxt = S3;
      4'b100_1: nxt = S4;
      default:  nxt = S0;
    endcase
    return nxt;
  endfunction

  function automatic logic is_divisible(input logic [REM_W-1:0] rem);
    return (rem == S0);
  endfunction

endpackage

// File: rtl/divisible_by_5_if.sv
// Bundle of the serial stream bit, the divisibility flag and the optional remainder.
interface div5_if;
  import div5_pkg::*;

  logic             in;
  logic             out;
  logic [REM_W-1:0] rem;

  modport master (
    output in,
    input  out,
    input  rem
  );

  modport slave (
    input  in,
    output out,
    output rem
  );

endinterface

// File: rtl/divisible_by_5_step.sv
// Purely combinational remainder update for one incoming stream bit.
module mod5_step
  import div5_pkg::*;
(
  input  logic [REM_W-1:0] i_rem,
  input  logic             i_bit,
  output logic [REM_W-1:0] o_next_rem
);

  assign o_next_rem = next_rem(i_rem, i_bit);

endmodule

// File: rtl/divisible_by_5.sv
// Serial MSB-first divisibility-by-5 checker (Moore FSM on the running remainder).
// Define DIV5_REM_OUT_EN to expose the registered remainder on port rem.
module divisible_by_5
  import div5_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
`ifdef DIV5_REM_OUT_EN
  output logic [REM_W-1:0] rem,
`endif
  output logic             out
);

  logic [REM_W-1:0] r_state;
  logic [REM_W-1:0] w_step_next;
  logic [REM_W-1:0] w_next;
  logic             w_out;

  mod5_step u_step (
    .i_rem      (r_state),
    .i_bit      (in),
    .o_next_rem (w_step_next)
  );

  // An empty stream is value 0, so reset parks the FSM in S0 with out high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S0;
    w_out  = 1'b0;
    w_next = w_step_next;
    w_out  = is_divisible(r_state);
  end

  assign out = w_out;

`ifdef DIV5_REM_OUT_EN
  assign rem = r_state;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && $isunknown(in)) begin
      $warning("divisible_by_5: unknown value on in, state forced to S0");
    end
  end
`endif

endmodule

// File: tb/tb_divisible_by_5.sv
// Directed and exhaustive stimulus for divisible_by_5 with a queue-based scoreboard.
module tb_divisible_by_5;
  import div5_pkg::*;

  logic clk = 1'b0;
  logic reset;
  div5_if bus ();

  always #5 clk = ~clk;

  divisible_by_5 dut (
    .clk   (clk),
    .reset (reset),
    .in    (bus.in),
`ifdef DIV5_REM_OUT_EN
    .rem   (bus.rem),
`endif
    .out   (bus.out)
  );

`ifndef DIV5_REM_OUT_EN
  assign bus.rem = '0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       out;
    logic [2:0] rem;
  } exp_t;
  exp_t sb[$];

  logic       t2_bits [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 1};
  logic       t2_out  [9] = '{1, 0, 0, 1, 1, 0, 0, 1, 0};
  logic [2:0] t2_rem  [9] = '{0, 1, 2, 0, 0, 1, 2, 0, 1};

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_rem(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed rem %0d expected rem %0d", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; drives one bit, samples after the next rising edge.
  task automatic step(input string tag, input logic b, input logic eo, input logic [2:0] er);
    exp_t e;
    bus.in = b;
    e.tag = tag;
    e.out = eo;
    e.rem = er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed %b expected an entry", tag, bus.out);
    end else begin
      e = sb.pop_front();
      check_bit(e.tag, bus.out, e.out);
`ifdef DIV5_REM_OUT_EN
      check_rem({e.tag, "_rem"}, bus.rem, e.rem);
`endif
    end
    @(negedge clk);
  endtask

  // Reset pulse between edges: out must rise without any clock edge.
  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    check_bit(tag, bus.out, 1'b1);
`ifdef DIV5_REM_OUT_EN
    check_rem({tag, "_rem"}, bus.rem, 3'd0);
`endif
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   acc;
    logic bb;

    // Test 1: asynchronous reset before any clock edge, in ignored during reset
    reset  = 1'b0;
    bus.in = 1'b1;
    #2;
    check_bit("t1_async", bus.out, 1'b1);
    @(posedge clk);
    #1;
    check_bit("t1_in_ignored", bus.out, 1'b1);
    @(negedge clk);
    reset  = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("t1_zero%0d", i), 1'b0, 1'b1, 3'd0);

    // Test 2: continue from value 0
    for (int i = 0; i < 9; i++) step($sformatf("t2[%0d]", i), t2_bits[i], t2_out[i], t2_rem[i]);

    // Test 3: 1111 -> 15, then 0 -> 30
    reset_pulse("t3_rst");
    step("t3[0]", 1'b1, 1'b0, 3'd1);
    step("t3[1]", 1'b1, 1'b0, 3'd3);
    step("t3[2]", 1'b1, 1'b0, 3'd2);
    step("t3[3]", 1'b1, 1'b1, 3'd0);
    step("t3[4]", 1'b0, 1'b1, 3'd0);

    // Test 4: mid-stream reset
    reset_pulse("t4_rst0");
    step("t4_pre0", 1'b1, 1'b0, 3'd1);
    step("t4_pre1", 1'b1, 1'b0, 3'd3);
    reset_pulse("t4_mid_rst");
    step("t4[0]", 1'b1, 1'b0, 3'd1);
    step("t4[1]", 1'b0, 1'b0, 3'd2);
    step("t4[2]", 1'b1, 1'b1, 3'd0);

    // Test 6 sequence (remainder compared only when the port exists)
    reset_pulse("t6_rst");
    step("t6[0]", 1'b1, 1'b0, 3'd1);
    step("t6[1]", 1'b0, 1'b0, 3'd2);
    step("t6[2]", 1'b0, 1'b0, 3'd4);
    step("t6[3]", 1'b1, 1'b0, 3'd4);
    step("t6[4]", 1'b0, 1'b0, 3'd3);

    // Test 5: every 8-bit value, every prefix, against the full integer value
    for (int v = 0; v < 256; v++) begin
      reset_pulse($sformatf("t5_rst_v%0d", v));
      acc = 0;
      for (int k = 7; k >= 0; k--) begin
        bb  = ((v >> k) & 1) != 0;
        acc = acc * 2 + int'(bb);
        step($sformatf("t5_v%0d_b%0d", v, k), bb, (acc % 5) == 0, 3'(acc % 5));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
